// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Optional auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD,
      RELEASE
   } state_t;

   localparam logic [3:0] ROWS_IDLE = 4'b1111;

   // Indexed [row][col]; row 3 carries the E/0/F/D bottom row of the pad.
   localparam logic [3:0] KEYMAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   function automatic logic [3:0] row_drive(input logic [1:0] row_idx);
      return ROWS_IDLE & ~(4'b0001 << row_idx);
   endfunction

endpackage

// File: rtl/col_priority_encoder.sv
// Picks the lowest-index active (low) column; col0 has highest priority.
module col_priority_encoder (
   input  logic [3:0] cols,
   output logic [1:0] col_idx,
   output logic       any_active
);

   always_comb begin
      col_idx    = 2'd0;
      any_active = 1'b1;
      if (!cols[0]) begin
         col_idx = 2'd0;
      end else if (!cols[1]) begin
         col_idx = 2'd1;
      end else if (!cols[2]) begin
         col_idx = 2'd2;
      end else if (!cols[3]) begin
         col_idx = 2'd3;
      end else begin
         any_active = 1'b0;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning 4x4 keypad reader with press and release debouncing.
// Define KEYPAD_REPEAT_EN to re-pulse key_valid every REPEAT_CYCLES while held.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_CYCLES     = 4096,
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int REPEAT_CYCLES   = 500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] synchronized_cols,
   output logic [3:0] rows,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (SCAN_CYCLES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_bad_params
      $error("keypad_scanner: illegal SCAN/DEBOUNCE/REPEAT cycle parameters");
   end

   state_t           state, state_n;
   logic [1:0]       row_idx, row_idx_n, row_inc;
   logic [1:0]       col_sel, col_sel_n;
   logic [CNT_W-1:0] count, count_n;
   logic [3:0]       rows_n, key_code_n;
   logic             key_valid_n, key_held_n;
   logic [1:0]       enc_idx;
   logic             enc_any;
   logic             col_low;

   col_priority_encoder u_col_priority_encoder (
      .cols       (synchronized_cols),
      .col_idx    (enc_idx),
      .any_active (enc_any)
   );

   assign col_low = ~synchronized_cols[col_sel];
   assign row_inc = row_idx + 2'd1;

`ifdef KEYPAD_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_CYCLES) + 1;
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
   logic [REP_W-1:0] rep_count, rep_count_n;
`endif

   // Next-state logic; all outputs are computed here and registered below.
   always_comb begin
      state_n     = state;
      row_idx_n   = row_idx;
      col_sel_n   = col_sel;
      count_n     = count;
      rows_n      = rows;
      key_code_n  = key_code;
      key_valid_n = 1'b0;
      key_held_n  = key_held;
`ifdef KEYPAD_REPEAT_EN
      rep_count_n = rep_count;
`endif
      case (state)
         SCAN: begin
            if (count == SCAN_LAST) begin
               count_n = '0;
               if (enc_any) begin
                  col_sel_n = enc_idx;
                  state_n   = DEBOUNCE;
               end else begin
                  row_idx_n = row_inc;
                  rows_n    = row_drive(row_inc);
               end
            end else begin
               count_n = count + CNT_W'(1);
            end
         end
         DEBOUNCE: begin
            if (!col_low) begin
               row_idx_n = row_inc;
               rows_n    = row_drive(row_inc);
               count_n   = '0;
               state_n   = SCAN;
            end else if (count == DEB_LAST) begin
               key_valid_n = 1'b1;
               key_code_n  = KEYMAP[row_idx][col_sel];
               key_held_n  = 1'b1;
               count_n     = '0;
               state_n     = HELD;
`ifdef KEYPAD_REPEAT_EN
               rep_count_n = '0;
`endif
            end else begin
               count_n = count + CNT_W'(1);
            end
         end
         HELD: begin
            if (!col_low) begin
               count_n = '0;
               state_n = RELEASE;
            end
`ifdef KEYPAD_REPEAT_EN
            else if (rep_count == REP_LAST) begin
               key_valid_n = 1'b1;
               rep_count_n = '0;
            end else begin
               rep_count_n = rep_count + REP_W'(1);
            end
`endif
         end
         RELEASE: begin
            if (col_low) begin
               count_n = '0;
               state_n = HELD;
`ifdef KEYPAD_REPEAT_EN
               rep_count_n = '0;
`endif
            end else if (count == DEB_LAST) begin
               key_held_n = 1'b0;
               row_idx_n  = row_inc;
               rows_n     = row_drive(row_inc);
               count_n    = '0;
               state_n    = SCAN;
            end else begin
               count_n = count + CNT_W'(1);
            end
         end
         default: begin
            state_n = SCAN;
            count_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SCAN;
         row_idx   <= 2'd0;
         col_sel   <= 2'd0;
         count     <= '0;
         rows      <= 4'b1110;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         state     <= state_n;
         row_idx   <= row_idx_n;
         col_sel   <= col_sel_n;
         count     <= count_n;
         rows      <= rows_n;
         key_code  <= key_code_n;
         key_valid <= key_valid_n;
         key_held  <= key_held_n;
      end
   end

`ifdef KEYPAD_REPEAT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         rep_count <= '0;
      end else begin
         rep_count <= rep_count_n;
      end
   end
`endif

endmodule
